// File: rtl/valve_mix_sequencer_pkg.sv
// Shared types and constants for the two-inlet valve/mixer sequencer.
package valve_seq_pkg;

    localparam int DOSE_W_DEF = 16;

    // Pneumatic line polarity: pressurised line holds the valve shut.
    localparam logic PN_CLOSED = 1'b1;
    localparam logic PN_OPEN   = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_OPEN_A   = 3'd1,
        ST_SETTLE_A = 3'd2,
        ST_OPEN_B   = 3'd3,
        ST_SETTLE_B = 3'd4,
        ST_MIX      = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/valve_mix_sequencer_if.sv
// Dose command handshake between host logic and the valve sequencer.
interface valve_mix_sequencer_if #(
    parameter int DOSE_W = valve_seq_pkg::DOSE_W_DEF
);
    logic              start_valid;
    logic              start_ready;
    logic [DOSE_W-1:0] dose_a;
    logic [DOSE_W-1:0] dose_b;
    logic [DOSE_W-1:0] mix_time;

    modport master (
        output start_valid, dose_a, dose_b, mix_time,
        input  start_ready
    );

    modport slave (
        input  start_valid, dose_a, dose_b, mix_time,
        output start_ready
    );
endinterface

// File: rtl/valve_mix_sequencer_phase_timer.sv
// Loadable down-counter shared by every timed phase; zero marks the last cycle of a phase.
module phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/valve_mix_sequencer.sv
// Timed non-overlapping valve A / valve B / mix sequencer.
// Optional abort input and aborted pulse enabled by defining VALVE_SEQ_ABORT_EN.
module valve_mix_sequencer
    import valve_seq_pkg::*;
#(
    parameter int DOSE_W        = DOSE_W_DEF,
    parameter int SETTLE_CYCLES = 8,
    parameter int SETTLE_W      = $clog2(SETTLE_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    valve_mix_sequencer_if.slave  cmd,
    output logic                  pn_a,
    output logic                  pn_b,
    output logic [2:0]            phase,
    output logic                  busy,
    output logic                  done
`ifdef VALVE_SEQ_ABORT_EN
    ,
    input  logic                  abort,
    output logic                  aborted
`endif
);
    localparam int TW = (DOSE_W > SETTLE_W) ? DOSE_W : SETTLE_W;

    state_t            state, nxt;
    logic [DOSE_W-1:0] lat_a, lat_b, lat_m;
    logic [DOSE_W-1:0] src_a, src_b, src_m;
    logic              accept, abort_now;
    logic              t_load, t_zero;
    logic [TW-1:0]     t_value;

    // First enabled phase among A, B, mix; DONE when none remain.
    function automatic state_t pick(input logic use_a, input logic use_b, input logic use_m);
        if (use_a)      return ST_OPEN_A;
        else if (use_b) return ST_OPEN_B;
        else if (use_m) return ST_MIX;
        else            return ST_DONE;
    endfunction

    always_comb begin
        accept    = (state == ST_IDLE) && cmd.start_valid;
`ifdef VALVE_SEQ_ABORT_EN
        abort_now = (state != ST_IDLE) && abort;
`else
        abort_now = 1'b0;
`endif
        // On the accepting edge the latches are not yet loaded, so read the command directly.
        src_a = accept ? cmd.dose_a   : lat_a;
        src_b = accept ? cmd.dose_b   : lat_b;
        src_m = accept ? cmd.mix_time : lat_m;

        nxt = state;
        unique case (state)
            ST_IDLE:     if (accept) nxt = pick(src_a != '0, src_b != '0, src_m != '0);
            ST_OPEN_A:   if (t_zero) nxt = ST_SETTLE_A;
            ST_SETTLE_A: if (t_zero) nxt = pick(1'b0, src_b != '0, src_m != '0);
            ST_OPEN_B:   if (t_zero) nxt = ST_SETTLE_B;
            ST_SETTLE_B: if (t_zero) nxt = pick(1'b0, 1'b0, src_m != '0);
            ST_MIX:      if (t_zero) nxt = ST_DONE;
            ST_DONE:     nxt = ST_IDLE;
            default:     nxt = ST_IDLE;
        endcase
        if (abort_now) nxt = ST_IDLE;

        t_value = '0;
        unique case (nxt)
            ST_OPEN_A:                t_value = TW'(src_a - 1'b1);
            ST_OPEN_B:                t_value = TW'(src_b - 1'b1);
            ST_MIX:                   t_value = TW'(src_m - 1'b1);
            ST_SETTLE_A, ST_SETTLE_B: t_value = TW'(SETTLE_CYCLES - 1);
            default:                  t_value = '0;
        endcase
        t_load = (nxt != state) && (nxt != ST_IDLE) && (nxt != ST_DONE);
    end

    phase_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (t_load),
        .load_value (t_value),
        .zero       (t_zero)
    );

    // Outputs are registered from nxt so they line up with the registered state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            pn_a            <= PN_CLOSED;
            pn_b            <= PN_CLOSED;
            busy            <= 1'b0;
            done            <= 1'b0;
            cmd.start_ready <= 1'b1;
            lat_a           <= '0;
            lat_b           <= '0;
            lat_m           <= '0;
`ifdef VALVE_SEQ_ABORT_EN
            aborted         <= 1'b0;
`endif
        end else begin
            state           <= nxt;
            pn_a            <= (nxt == ST_OPEN_A) ? PN_OPEN : PN_CLOSED;
            pn_b            <= (nxt == ST_OPEN_B) ? PN_OPEN : PN_CLOSED;
            busy            <= (nxt != ST_IDLE);
            done            <= (nxt == ST_DONE);
            cmd.start_ready <= (nxt == ST_IDLE);
            if (accept) begin
                lat_a <= cmd.dose_a;
                lat_b <= cmd.dose_b;
                lat_m <= cmd.mix_time;
            end
`ifdef VALVE_SEQ_ABORT_EN
            aborted         <= abort_now;
`endif
        end
    end

    assign phase = state;

endmodule
